// File: rtl/bp_me_mem_responder_lite.sv
// BedRock memory-side responder: accepts one mem_cmd at a time, services it
// against an internal block-organized RAM after a fixed latency, and returns
// a mem_resp that echoes the command header. Used as a DRAM stand-in.
module bp_me_mem_responder_lite #(
  parameter int                         paddr_width_p   = 40,
  parameter int                         block_width_p   = 512,
  parameter int                         payload_width_p = 16,
  parameter int                         els_p           = 1024,
  parameter logic [paddr_width_p-1:0]   mem_offset_p    = '0,
  parameter int                         latency_p       = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,

  input  logic                         mem_cmd_v_i,
  output logic                         mem_cmd_ready_o,
  input  logic [3:0]                   mem_cmd_msg_type_i,
  input  logic [paddr_width_p-1:0]     mem_cmd_addr_i,
  input  logic [2:0]                   mem_cmd_size_i,
  input  logic [payload_width_p-1:0]   mem_cmd_payload_i,
  input  logic [block_width_p-1:0]     mem_cmd_data_i,

  output logic                         mem_resp_v_o,
  input  logic                         mem_resp_yumi_i,
  output logic [3:0]                   mem_resp_msg_type_o,
  output logic [paddr_width_p-1:0]     mem_resp_addr_o,
  output logic [2:0]                   mem_resp_size_o,
  output logic [payload_width_p-1:0]   mem_resp_payload_o,
  output logic [block_width_p-1:0]     mem_resp_data_o,

  output logic                         err_o
);

  localparam int block_bytes_lp    = block_width_p / 8;
  localparam int lg_block_bytes_lp = $clog2(block_bytes_lp);
  localparam int lg_els_lp         = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_width_lp      = $clog2(latency_p + 1);
  localparam int paddr_ext_lp      = paddr_width_p + 1;

  // Total bytes of storage, one bit wider than an address so it cannot overflow.
  localparam logic [paddr_width_p:0] mem_bytes_lp =
    paddr_ext_lp'(longint'(els_p) * longint'(block_bytes_lp));
  localparam logic [2:0] max_size_lp = 3'(lg_block_bytes_lp);

  localparam logic [1:0] idle_s = 2'd0;
  localparam logic [1:0] wait_s = 2'd1;
  localparam logic [1:0] resp_s = 2'd2;

  localparam logic [3:0] msg_rd_lp    = 4'd0;
  localparam logic [3:0] msg_wr_lp    = 4'd1;
  localparam logic [3:0] msg_uc_rd_lp = 4'd2;
  localparam logic [3:0] msg_uc_wr_lp = 4'd3;

  logic [1:0]                 state_q, state_d;
  logic [cnt_width_lp-1:0]    cnt_q, cnt_d;
  logic [3:0]                 msg_type_q, msg_type_d;
  logic [paddr_width_p-1:0]   addr_q, addr_d;
  logic [2:0]                 size_q, size_d;
  logic [payload_width_p-1:0] payload_q, payload_d;
  logic [block_width_p-1:0]   cmd_data_q, cmd_data_d;
  logic [block_width_p-1:0]   resp_data_q, resp_data_d;
  logic                       err_q, err_d;

  logic [block_width_p-1:0]   mem_q [els_p];

  logic [paddr_width_p:0]     off_ext;
  logic [paddr_width_p-1:0]   off;
  logic                       in_range;
  logic                       is_rd, is_wr, cmd_ok;
  logic [lg_els_lp-1:0]       idx;
  logic [2:0]                 size_eff;
  logic [lg_block_bytes_lp-1:0] span_m1;
  logic [lg_block_bytes_lp-1:0] byte_off;
  logic [block_width_p-1:0]   blk_rdata, blk_wdata, rd_chunk;
  logic                       mem_we;

  // Address decode and size clamp for the registered command.
  always_comb begin
    // The borrow out of the subtraction flags addresses below the base.
    off_ext  = {1'b0, addr_q} - {1'b0, mem_offset_p};
    off      = off_ext[paddr_width_p-1:0];
    in_range = ~off_ext[paddr_width_p] && ({1'b0, off} < mem_bytes_lp);
    idx      = off[lg_block_bytes_lp +: lg_els_lp];
    is_rd    = (msg_type_q == msg_rd_lp) || (msg_type_q == msg_uc_rd_lp);
    is_wr    = (msg_type_q == msg_wr_lp) || (msg_type_q == msg_uc_wr_lp);
    cmd_ok   = in_range && (is_rd || is_wr);
    size_eff = (size_q > max_size_lp) ? max_size_lp : size_q;
    // For a full-block access the shift wraps to zero, so the mask clears every offset bit.
    span_m1  = (lg_block_bytes_lp'(1) << size_eff) - lg_block_bytes_lp'(1);
    byte_off = off[lg_block_bytes_lp-1:0] & ~span_m1;
  end

  // Byte-merged write block and replicated read chunk for the addressed block.
  always_comb begin
    int n_bytes;
    int base;
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latches).
    n_bytes   = 1 << size_eff;
    base      = int'(byte_off);
    blk_rdata = mem_q[idx];
    blk_wdata = blk_rdata;
    rd_chunk  = '0;
    for (int b = 0; b < block_bytes_lp; b++) begin
      if ((b >= base) && (b < base + n_bytes)) begin
        blk_wdata[8*b +: 8] = cmd_data_q[8*((b - base) & (block_bytes_lp - 1)) +: 8];
      end
      rd_chunk[8*b +: 8] = blk_rdata[8*(base + (b & (n_bytes - 1))) +: 8];
    end
  end

  // Command sequencing: IDLE accepts, WAIT counts down and accesses RAM, RESP holds until yumi.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    msg_type_d  = msg_type_q;
    addr_d      = addr_q;
    size_d      = size_q;
    payload_d   = payload_q;
    cmd_data_d  = cmd_data_q;
    resp_data_d = resp_data_q;
    err_d       = err_q;
    mem_we      = 1'b0;
    case (state_q)
      idle_s: begin
        if (mem_cmd_v_i) begin
          msg_type_d = mem_cmd_msg_type_i;
          addr_d     = mem_cmd_addr_i;
          size_d     = mem_cmd_size_i;
          payload_d  = mem_cmd_payload_i;
          cmd_data_d = mem_cmd_data_i;
          cnt_d      = cnt_width_lp'(latency_p - 1);
          state_d    = wait_s;
        end
      end
      wait_s: begin
        if (cnt_q == '0) begin
          state_d     = resp_s;
          resp_data_d = '0;
          if (!cmd_ok) begin
            err_d = 1'b1;
          end else if (is_wr) begin
            mem_we = 1'b1;
          end else begin
            resp_data_d = rd_chunk;
          end
        end else begin
          cnt_d = cnt_q - cnt_width_lp'(1);
        end
      end
      resp_s: begin
        if (mem_resp_yumi_i) begin
          state_d = idle_s;
        end
      end
      default: state_d = idle_s;
    endcase
  end

  // Control and response registers; async reset aborts any in-flight command.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    if (!reset_ni) begin
      state_q     <= idle_s;
      cnt_q       <= '0;
      msg_type_q  <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      payload_q   <= '0;
      cmd_data_q  <= '0;
      resp_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      msg_type_q  <= msg_type_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      payload_q   <= payload_d;
      cmd_data_q  <= cmd_data_d;
      resp_data_q <= resp_data_d;
      err_q       <= err_d;
    end
  end

  // Block RAM write port, used only on the WAIT->RESP edge.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array has no reset; a RAM macro cannot clear itself and contents stay undefined until written.
    if (mem_we) begin
      mem_q[idx] <= blk_wdata;
    end
  end

  assign mem_cmd_ready_o     = (state_q == idle_s);
  assign mem_resp_v_o        = (state_q == resp_s);
  assign mem_resp_msg_type_o = msg_type_q;
  assign mem_resp_addr_o     = addr_q;
  assign mem_resp_size_o     = size_q;
  assign mem_resp_payload_o  = payload_q;
  assign mem_resp_data_o     = resp_data_q;
  assign err_o               = err_q;

endmodule
